e_mdu: RTL and testbench
========================

Name: e_mdu

Overview:
- Iterative multiply/divide unit in the E stage of the 5-stage MIPS pipeline.
- Consumes the rs/rt operands read in D. These are the register file's read data after D-stage forwarding and the D/E pipeline register.
- Holds the architectural HI/LO registers and reports busy to the hazard unit, which stalls D on mult/div/mfhi/mflo/mthi/mtlo while busy.
- mfhi/mflo read o_hi/o_lo through the E-stage result mux.

Parameters:
- MULT_CYCLES, 5, busy duration in cycles for mult/multu (legal range 1..15).
- DIV_CYCLES, 10, busy duration in cycles for div/divu (legal range 1..15).

Ports:
- i_clk  input  1  clock, rising edge.
- i_reset  input  1  reset, synchronous, active-high.
- i_start  input  1  E-stage instruction is an MDU op; qualified by i_op.
- i_op  input  3  0=mult, 1=multu, 2=div, 3=divu, 4=mthi, 5=mtlo, 6/7=reserved (no effect).
- i_rs  input  32  operand A (dividend / mthi-mtlo source).
- i_rt  input  32  operand B (divisor).
- o_busy  output  1  operation in progress.
- o_hi  output  32  architectural HI.
- o_lo  output  32  architectural LO.

Behaviour:
- Reset: synchronous to i_clk, active-high. Clears o_hi, o_lo, o_busy, the internal counter, and the pending HI/LO shadow values.
- Reset mid-operation aborts the operation; no HI/LO update occurs.
- State machine: IDLE, RUN.
- IDLE, i_start=1, i_op in 0..3:
  - Latch the full 64-bit result into shadow HI/LO at that edge.
  - Load the counter with MULT_CYCLES or DIV_CYCLES; go to RUN.
  - o_busy=1 from the next cycle.
- RUN: counter decrements each cycle. When the counter reaches 1, the next edge copies shadow HI/LO into o_hi/o_lo, clears o_busy, and returns to IDLE.
- Timing: start at edge T gives o_busy high for exactly N cycles, and new o_hi/o_lo are visible after edge T+N.
- IDLE, i_start=1, i_op=4/5: o_hi (or o_lo) <= i_rs at that edge. o_busy stays 0.
- Arithmetic:
  - mult: signed 32x32 -> 64.
  - multu: unsigned 32x32 -> 64.
  - HI = upper 32 bits, LO = lower 32 bits.
  - div/divu: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0x00000000.
  - Divisor 0: operation still runs DIV_CYCLES busy cycles, but o_hi/o_lo retain their prior values.
- i_start while in RUN: ignored for every op, including mthi/mtlo. The hazard unit guarantees this does not happen; the bench checks that no state changes.
- Reserved i_op: no state change, no busy.
- o_hi/o_lo are stable throughout RUN; they show the pre-operation values until the completing edge.

Optional Feature:
- Macro: MDU_START_BUSY_EN.
- Defined: o_busy = registered busy OR (i_start AND i_op in 0..3), so busy is asserted combinationally in the start cycle. The busy window visible to the hazard unit becomes N+1 cycles (T-1 through T+N-1 relative to the start edge T).
- Undefined: o_busy is purely registered, with the N-cycle window as specified above.
- HI/LO timing is identical in both builds.

Test Plan:
- Reset: hold i_reset for 2 cycles mid-RUN of a div -> o_busy=0, o_hi=o_lo=0, and no late update appears after reset releases.
- mult 0xFFFFFFFE x 0x00000003 (signed), MULT_CYCLES=5 -> o_busy high exactly 5 cycles; then o_hi=0xFFFFFFFF, o_lo=0xFFFFFFFA. multu with the same operands -> o_hi=0x00000002, o_lo=0xFFFFFFFA.
- div -7 / 2 (0xFFFFFFF9 / 0x00000002) -> o_lo=0xFFFFFFFD, o_hi=0xFFFFFFFF after 10 cycles. divu 100 / 7 -> o_lo=14, o_hi=2.
- div 0x80000000 / 0xFFFFFFFF -> o_lo=0x80000000, o_hi=0. Then div 5 / 0 -> busy 10 cycles, o_hi/o_lo unchanged.
- mthi 0x12345678 in IDLE -> o_hi=0x12345678 the next cycle, o_busy never asserts. mtlo issued during a mult's RUN -> ignored; o_lo equals the mult result at completion.
- With MDU_START_BUSY_EN: start mult -> o_busy high in the start cycle plus the 5 following cycles. Without the macro: low in the start cycle, high for the next 5 cycles.

Source files
------------

// File: rtl/e_mdu_if.sv
// ----------------------------------------------------------------------------
// e_mdu_if : operand/result bundle between the E stage and the multiply/divide
//            unit.
//
// Signals
//   i_start  E-stage instruction is an MDU op (qualified by i_op)
//   i_op     0=mult 1=multu 2=div 3=divu 4=mthi 5=mtlo 6/7=reserved
//   i_rs     operand A (dividend / mthi-mtlo source)
//   i_rt     operand B (divisor)
//   o_busy   operation in progress (to hazard unit)
//   o_hi     architectural HI
//   o_lo     architectural LO
//
// Modports
//   master   pipeline side (drives op and operands, observes busy/HI/LO)
//   slave    MDU side
// ----------------------------------------------------------------------------
interface e_mdu_if;
    logic        i_start;
    logic [2:0]  i_op;
    logic [31:0] i_rs;
    logic [31:0] i_rt;
    logic        o_busy;
    logic [31:0] o_hi;
    logic [31:0] o_lo;

    modport master (
        output i_start, i_op, i_rs, i_rt,
        input  o_busy, o_hi, o_lo
    );

    modport slave (
        input  i_start, i_op, i_rs, i_rt,
        output o_busy, o_hi, o_lo
    );
endinterface

// File: rtl/e_mdu.sv
// ----------------------------------------------------------------------------
// e_mdu : iterative-latency multiply/divide unit for the E stage.
//
// The full 64-bit result is computed in the start cycle and parked in a
// shadow register; HI/LO are only updated once the busy window has elapsed,
// so the rest of the pipeline sees the same latency a real iterative unit
// would have.
//
// Ports
//   i_clk     clock, rising edge
//   i_reset   synchronous, active-high reset
//   mdu       e_mdu_if.slave : i_start, i_op, i_rs, i_rt in; o_busy, o_hi,
//             o_lo out
//
// Parameters
//   MULT_CYCLES  busy cycles for mult/multu (1..15)
//   DIV_CYCLES   busy cycles for div/divu   (1..15)
//
// Build option
//   MDU_START_BUSY_EN  when defined, o_busy is also raised combinationally in
//                      the cycle a mult/div is presented, so the hazard unit
//                      sees an N+1 cycle window. HI/LO timing is unchanged.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | accepting ops; mthi/mtlo write directly, mult/div launch
// S_RUN  | counting down; HI/LO frozen until the counter reaches 1
// ----------------------------------------------------------------------------
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic     i_clk,
    input  logic     i_reset,
    e_mdu_if.slave   mdu
);

    localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] shadow_q, shadow_d;
    logic        commit_q, commit_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    // ---------------------------------------------------------------- datapath
    // Even op codes are the signed variants.
    logic        signed_op;
    logic        arith_start;
    logic [63:0] mul_a, mul_b, product;

    assign signed_op   = ~mdu.i_op[0];
    assign arith_start = mdu.i_start & ~mdu.i_op[2];

    // Sign/zero extension to 64 bits lets one multiplier serve both flavours;
    // the low 64 bits of the product are exact in either case.
    assign mul_a   = {{32{signed_op & mdu.i_rs[31]}}, mdu.i_rs};
    assign mul_b   = {{32{signed_op & mdu.i_rt[31]}}, mdu.i_rt};
    assign product = mul_a * mul_b;

    // Division runs on magnitudes so that 0x80000000 / -1 needs no special
    // case: the magnitude quotient 0x80000000 negates back to itself.
    logic        neg_a, neg_b, div_zero;
    logic [31:0] mag_a, mag_b, mag_b_safe;
    logic [31:0] quo_u, rem_u, quo, rem;

    assign neg_a      = signed_op & mdu.i_rs[31];
    assign neg_b      = signed_op & mdu.i_rt[31];
    assign mag_a      = neg_a ? (32'd0 - mdu.i_rs) : mdu.i_rs;
    assign mag_b      = neg_b ? (32'd0 - mdu.i_rt) : mdu.i_rt;
    assign div_zero   = (mdu.i_rt == 32'd0);
    assign mag_b_safe = div_zero ? 32'd1 : mag_b;
    assign quo_u      = mag_a / mag_b_safe;
    assign rem_u      = mag_a % mag_b_safe;
    assign quo        = (neg_a ^ neg_b) ? (32'd0 - quo_u) : quo_u;
    assign rem        = neg_a ? (32'd0 - rem_u) : rem_u;

    // ---------------------------------------------------------------- control
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        commit_d = commit_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        unique case (state_q)
            S_IDLE: begin
                if (mdu.i_start) begin
                    unique case (mdu.i_op)
                        3'd0, 3'd1: begin
                            shadow_d = product;
                            commit_d = 1'b1;
                            cnt_d    = MULT_N;
                            state_d  = S_RUN;
                        end
                        3'd2, 3'd3: begin
                            shadow_d = {rem, quo};
                            // Divide by zero keeps the full busy window but
                            // leaves HI/LO untouched.
                            commit_d = ~div_zero;
                            cnt_d    = DIV_N;
                            state_d  = S_RUN;
                        end
                        3'd4:    hi_d = mdu.i_rs;
                        3'd5:    lo_d = mdu.i_rs;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                if (cnt_q <= 4'd1) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                    if (commit_q) begin
                        hi_d = shadow_q[63:32];
                        lo_d = shadow_q[31:0];
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            shadow_q <= 64'd0;
            commit_q <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            commit_q <= commit_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    // ---------------------------------------------------------------- outputs
`ifdef MDU_START_BUSY_EN
    assign mdu.o_busy = (state_q == S_RUN) | arith_start;
`else
    assign mdu.o_busy = (state_q == S_RUN);
`endif
    assign mdu.o_hi = hi_q;
    assign mdu.o_lo = lo_q;

    // Only consumed by the start-cycle busy option.
    logic unused_ok;
    assign unused_ok = arith_start;

endmodule

// File: tb/tb_e_mdu.sv
module tb_e_mdu;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

`ifdef MDU_START_BUSY_EN
    localparam bit START_BUSY = 1'b1;
`else
    localparam bit START_BUSY = 1'b0;
`endif

    logic i_clk = 1'b0;
    logic i_reset;

    always #5 i_clk = ~i_clk;

    e_mdu_if mdu_if ();

    e_mdu #(
        .MULT_CYCLES (MULT_N),
        .DIV_CYCLES  (DIV_N)
    ) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .mdu     (mdu_if.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp_hi, exp_lo;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_cmp++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, expv, $time);
        end
    endtask

    // Architectural reference: what HI/LO become after an op completes.
    function automatic void model(input logic [2:0] op, input logic [31:0] a,
                                  input logic [31:0] b,
                                  inout logic [31:0] hi, inout logic [31:0] lo);
        longint      sa, sb, q, r;
        logic [63:0] p;
        case (op)
            3'd0: begin
                p  = 64'(longint'(signed'(a)) * longint'(signed'(b)));
                hi = p[63:32];
                lo = p[31:0];
            end
            3'd1: begin
                p  = {32'd0, a} * {32'd0, b};
                hi = p[63:32];
                lo = p[31:0];
            end
            3'd2: if (b != 0) begin
                sa = longint'(signed'(a));
                sb = longint'(signed'(b));
                q  = sa / sb;
                r  = sa % sb;
                lo = q[31:0];
                hi = r[31:0];
            end
            3'd3: if (b != 0) begin
                lo = a / b;
                hi = a % b;
            end
            3'd4: hi = a;
            3'd5: lo = a;
            default: ;
        endcase
    endfunction

    // Issue one op starting just after a falling edge. For mult/div, the busy
    // window and frozen HI/LO are checked every cycle. inj >= 0 presents an
    // mtlo in that RUN cycle, which must be ignored.
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b, input int inj);
        logic [31:0] old_hi, old_lo;
        int n;
        old_hi = exp_hi;
        old_lo = exp_lo;
        model(op, a, b, exp_hi, exp_lo);
        n = (op <= 3'd1) ? MULT_N : (op <= 3'd3) ? DIV_N : 0;

        mdu_if.i_start = 1'b1;
        mdu_if.i_op    = op;
        mdu_if.i_rs    = a;
        mdu_if.i_rt    = b;
        #1;
        check({tag, ".busy_start"}, 32'(mdu_if.o_busy), 32'(START_BUSY && n > 0));
        @(posedge i_clk);
        #1;
        mdu_if.i_start = 1'b0;
        mdu_if.i_op    = 3'($urandom_range(0, 7));
        mdu_if.i_rs    = $urandom;
        mdu_if.i_rt    = $urandom;

        for (int k = 0; k < n; k++) begin
            @(negedge i_clk);
            check({tag, ".busy_run"}, 32'(mdu_if.o_busy), 32'd1);
            check({tag, ".hi_frozen"}, mdu_if.o_hi, old_hi);
            check({tag, ".lo_frozen"}, mdu_if.o_lo, old_lo);
            if (k == inj) begin
                mdu_if.i_start = 1'b1;
                mdu_if.i_op    = 3'd5;
                mdu_if.i_rs    = $urandom;
            end else begin
                mdu_if.i_start = 1'b0;
            end
        end
        @(negedge i_clk);
        mdu_if.i_start = 1'b0;
        #1;
        check({tag, ".busy_done"}, 32'(mdu_if.o_busy), 32'd0);
        check({tag, ".hi"}, mdu_if.o_hi, exp_hi);
        check({tag, ".lo"}, mdu_if.o_lo, exp_lo);
        @(negedge i_clk);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        int          inj;

        i_reset        = 1'b1;
        mdu_if.i_start = 1'b0;
        mdu_if.i_op    = 3'd0;
        mdu_if.i_rs    = 32'd0;
        mdu_if.i_rt    = 32'd0;
        exp_hi         = 32'd0;
        exp_lo         = 32'd0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b0;
        check("rst.busy", 32'(mdu_if.o_busy), 32'd0);
        check("rst.hi", mdu_if.o_hi, 32'd0);
        check("rst.lo", mdu_if.o_lo, 32'd0);

        // Directed cases with hand-derived results.
        run_op("mult", 3'd0, 32'hFFFF_FFFE, 32'h0000_0003, -1);
        check("mult.hi_const", mdu_if.o_hi, 32'hFFFF_FFFF);
        check("mult.lo_const", mdu_if.o_lo, 32'hFFFF_FFFA);
        run_op("multu", 3'd1, 32'hFFFF_FFFE, 32'h0000_0003, -1);
        check("multu.hi_const", mdu_if.o_hi, 32'h0000_0002);
        check("multu.lo_const", mdu_if.o_lo, 32'hFFFF_FFFA);
        run_op("div", 3'd2, 32'hFFFF_FFF9, 32'h0000_0002, -1);
        check("div.lo_const", mdu_if.o_lo, 32'hFFFF_FFFD);
        check("div.hi_const", mdu_if.o_hi, 32'hFFFF_FFFF);
        run_op("divu", 3'd3, 32'd100, 32'd7, -1);
        check("divu.lo_const", mdu_if.o_lo, 32'd14);
        check("divu.hi_const", mdu_if.o_hi, 32'd2);
        run_op("divovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        check("divovf.lo_const", mdu_if.o_lo, 32'h8000_0000);
        check("divovf.hi_const", mdu_if.o_hi, 32'h0000_0000);
        run_op("div0", 3'd2, 32'd5, 32'd0, -1);
        check("div0.lo_const", mdu_if.o_lo, 32'h8000_0000);
        check("div0.hi_const", mdu_if.o_hi, 32'h0000_0000);
        run_op("mthi", 3'd4, 32'h1234_5678, 32'd0, -1);
        check("mthi.hi_const", mdu_if.o_hi, 32'h1234_5678);
        run_op("mult_mtlo", 3'd0, 32'h0000_1000, 32'h0000_0010, 2);
        check("mult_mtlo.lo_const", mdu_if.o_lo, 32'h0001_0000);
        run_op("mult_mtlo_last", 3'd1, 32'd9, 32'd9, MULT_N - 1);
        run_op("rsvd6", 3'd6, 32'hDEAD_BEEF, 32'h1, -1);
        run_op("rsvd7", 3'd7, 32'hCAFE_F00D, 32'h2, -1);

        // Randomized ops against the reference model.
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 9));
                2: b = 32'hFFFF_FFFF;
                default: ;
            endcase
            inj = ($urandom_range(0, 3) == 0) ? $urandom_range(0, MULT_N - 1) : -1;
            run_op("rand", op, a, b, inj);
        end

        // Reset in the middle of a div: abort, clear, and no late write.
        mdu_if.i_start = 1'b1;
        mdu_if.i_op    = 3'd3;
        mdu_if.i_rs    = 32'd1000;
        mdu_if.i_rt    = 32'd3;
        @(posedge i_clk);
        #1;
        mdu_if.i_start = 1'b0;
        repeat (3) @(negedge i_clk);
        check("rstmid.busy_before", 32'(mdu_if.o_busy), 32'd1);
        i_reset = 1'b1;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b0;
        exp_hi  = 32'd0;
        exp_lo  = 32'd0;
        check("rstmid.busy", 32'(mdu_if.o_busy), 32'd0);
        check("rstmid.hi", mdu_if.o_hi, exp_hi);
        check("rstmid.lo", mdu_if.o_lo, exp_lo);
        for (int k = 0; k < DIV_N + 2; k++) begin
            @(negedge i_clk);
            check("rstmid.busy_after", 32'(mdu_if.o_busy), 32'd0);
            check("rstmid.hi_after", mdu_if.o_hi, 32'd0);
            check("rstmid.lo_after", mdu_if.o_lo, 32'd0);
        end

        // Unit must still work normally after the abort.
        run_op("post_rst", 3'd0, 32'hFFFF_FFFE, 32'h0000_0003, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
